// File: rtl/decrypt_pkg.sv
// Shared types, constants and the LFSR step function for the decrypt engine.
package decrypt_pkg;

   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned LFSR_W    = 7;
   localparam int unsigned TAP_IDX_W = 4;
   localparam int unsigned PERR_W    = 7;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned N_TAPS    = 9;
   localparam int unsigned PRE_CHECK = 10;

   localparam logic [DATA_W-1:0]    PAD_CHAR = 8'h20;
   localparam logic [TAP_IDX_W-1:0] TAP_NONE = 4'hF;

   // Candidate feedback patterns; index order sets match priority.
   localparam logic [LFSR_W-1:0] TAP_TABLE [N_TAPS] = '{
      7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
   };

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEARCH,
      DECRYPT,
      DONE
   } state_e;

   // Shift left, feedback is the parity of the tapped bits.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                   input logic [LFSR_W-1:0] tap);
      return {s[LFSR_W-2:0], ^(s & tap)};
   endfunction

endpackage

// File: rtl/lfsr7_step.sv
// 7-bit LFSR state register with load and step controls.
// Ports: clk_i/rst_ni clock and async reset; load_i loads load_val_i;
// step_i advances using tap_i; state_o current state; step_c_o the
// combinational next state for the current tap.
module lfsr7_step
   import decrypt_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [LFSR_W-1:0] load_val_i,
   input  logic              step_i,
   input  logic [LFSR_W-1:0] tap_i,
   output logic [LFSR_W-1:0] state_o,
   output logic [LFSR_W-1:0] step_c_o
);

   logic [LFSR_W-1:0] state_q, state_d;

   assign step_c_o = lfsr_step(state_q, tap_i);
   assign state_o  = state_q;

   // Load wins over step.
   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = load_val_i;
      end else if (step_i) begin
         state_d = step_c_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/lfsr_decrypt_engine.sv
// LFSR stream decryptor: recovers tap pattern and seed from a space preamble,
// then decrypts MSG_LEN bytes from MSG_BASE into OUT_BASE.
// Ports: clk, init_n (async active-low reset); req/ack start/complete
// handshake; mem_addr/mem_rd_data/mem_wr_en/mem_wr_data data-memory port
// (async read, sync write); tap_sel, lfsr_seed, match_err, parity_errs status.
module lfsr_decrypt_engine
   import decrypt_pkg::*;
#(
   parameter int unsigned MSG_BASE = 64,
   parameter int unsigned OUT_BASE = 0,
   parameter int unsigned MSG_LEN  = 64
) (
   input  logic                 clk,
   input  logic                 init_n,
   input  logic                 req,
   output logic                 ack,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [DATA_W-1:0]    mem_rd_data,
   output logic                 mem_wr_en,
   output logic [DATA_W-1:0]    mem_wr_data,
   output logic [TAP_IDX_W-1:0] tap_sel,
   output logic [LFSR_W-1:0]    lfsr_seed,
   output logic                 match_err,
   output logic [PERR_W-1:0]    parity_errs
);

   state_e                state_q, state_d;
   logic                  req_q, req_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [TAP_IDX_W-1:0]  t_q, t_d;
   logic [TAP_IDX_W-1:0]  j_q, j_d;
   logic                  wr_phase_q, wr_phase_d;
   logic                  ack_q, ack_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic                  mem_wr_en_q, mem_wr_en_d;
   logic [DATA_W-1:0]     mem_wr_data_q, mem_wr_data_d;
   logic [TAP_IDX_W-1:0]  tap_sel_q, tap_sel_d;
   logic [LFSR_W-1:0]     seed_q, seed_d;
   logic                  match_err_q, match_err_d;
   logic [PERR_W-1:0]     perr_q, perr_d;
   logic [LFSR_W-1:0]     pre_q [PRE_CHECK];

   logic                  lfsr_load_c, lfsr_step_c, pre_we_c;
   logic [LFSR_W-1:0]     lfsr_s, lfsr_nxt;
   logic [LFSR_W-1:0]     pre_val_c;
   logic                  parity_bad_c;

   assign pre_val_c    = mem_rd_data[LFSR_W-1:0] ^ PAD_CHAR[LFSR_W-1:0];
   assign parity_bad_c = mem_rd_data[DATA_W-1] != ^mem_rd_data[LFSR_W-1:0];

   // Single LFSR reused for pattern search and keystream generation.
   lfsr7_step u_lfsr (
      .clk_i      (clk),
      .rst_ni     (init_n),
      .load_i     (lfsr_load_c),
      .load_val_i (pre_q[0]),
      .step_i     (lfsr_step_c),
      .tap_i      (TAP_TABLE[t_q]),
      .state_o    (lfsr_s),
      .step_c_o   (lfsr_nxt)
   );

   // Next-state and registered-output logic; addresses are issued one
   // cycle ahead so they are valid in the cycle that uses them.
   always_comb begin
      state_d       = state_q;
      req_d         = 1'b0;
      cnt_d         = cnt_q;
      t_d           = t_q;
      j_d           = j_q;
      wr_phase_d    = wr_phase_q;
      ack_d         = 1'b0;
      mem_addr_d    = '0;
      mem_wr_en_d   = 1'b0;
      mem_wr_data_d = '0;
      tap_sel_d     = tap_sel_q;
      seed_d        = seed_q;
      match_err_d   = match_err_q;
      perr_d        = perr_q;
      lfsr_load_c   = 1'b0;
      lfsr_step_c   = 1'b0;
      pre_we_c      = 1'b0;

      case (state_q)
         IDLE: begin
            // req is only tracked here, so an edge seen while leaving DONE is ignored.
            req_d = req;
            if (req_q && !req) begin
               state_d     = LOAD;
               cnt_d       = '0;
               mem_addr_d  = ADDR_W'(MSG_BASE);
               tap_sel_d   = TAP_NONE;
               seed_d      = '0;
               match_err_d = 1'b0;
               perr_d      = '0;
            end
         end

         LOAD: begin
            pre_we_c = 1'b1;
            if (cnt_q == CNT_W'(PRE_CHECK - 1)) begin
               state_d     = SEARCH;
               seed_d      = pre_q[0];
               lfsr_load_c = 1'b1;
               t_d         = '0;
               j_d         = TAP_IDX_W'(1);
            end else begin
               cnt_d      = cnt_q + CNT_W'(1);
               mem_addr_d = ADDR_W'(MSG_BASE) + ADDR_W'(cnt_d);
            end
         end

         SEARCH: begin
            if (lfsr_nxt == pre_q[j_q]) begin
               if (j_q == TAP_IDX_W'(PRE_CHECK - 1)) begin
                  state_d     = DECRYPT;
                  tap_sel_d   = t_q;
                  lfsr_load_c = 1'b1;
                  cnt_d       = '0;
                  wr_phase_d  = 1'b0;
                  mem_addr_d  = ADDR_W'(MSG_BASE);
               end else begin
                  j_d         = j_q + TAP_IDX_W'(1);
                  lfsr_step_c = 1'b1;
               end
            end else if (t_q == TAP_IDX_W'(N_TAPS - 1)) begin
               state_d     = DONE;
               match_err_d = 1'b1;
            end else begin
               t_d         = t_q + TAP_IDX_W'(1);
               j_d         = TAP_IDX_W'(1);
               lfsr_load_c = 1'b1;
            end
         end

         DECRYPT: begin
            if (!wr_phase_q) begin
               // Read cycle: capture the byte straight into the write payload.
               wr_phase_d    = 1'b1;
               mem_addr_d    = ADDR_W'(OUT_BASE) + ADDR_W'(cnt_q);
               mem_wr_en_d   = 1'b1;
               mem_wr_data_d = {1'b0, mem_rd_data[LFSR_W-1:0] ^ lfsr_s};
               if (parity_bad_c && (perr_q != {PERR_W{1'b1}})) begin
                  perr_d = perr_q + PERR_W'(1);
               end
            end else begin
               lfsr_step_c = 1'b1;
               wr_phase_d  = 1'b0;
               if (cnt_q == CNT_W'(MSG_LEN - 1)) begin
                  state_d = DONE;
               end else begin
                  cnt_d      = cnt_q + CNT_W'(1);
                  mem_addr_d = ADDR_W'(MSG_BASE) + ADDR_W'(cnt_d);
               end
            end
         end

         DONE: begin
            if (req) begin
               state_d = IDLE;
            end else begin
               ack_d = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q       <= IDLE;
         req_q         <= 1'b0;
         cnt_q         <= '0;
         t_q           <= '0;
         j_q           <= '0;
         wr_phase_q    <= 1'b0;
         ack_q         <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_en_q   <= 1'b0;
         mem_wr_data_q <= '0;
         tap_sel_q     <= TAP_NONE;
         seed_q        <= '0;
         match_err_q   <= 1'b0;
         perr_q        <= '0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         cnt_q         <= cnt_d;
         t_q           <= t_d;
         j_q           <= j_d;
         wr_phase_q    <= wr_phase_d;
         ack_q         <= ack_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_wr_data_q <= mem_wr_data_d;
         tap_sel_q     <= tap_sel_d;
         seed_q        <= seed_d;
         match_err_q   <= match_err_d;
         perr_q        <= perr_d;
      end
   end

   // Preamble keystream registers, filled during LOAD.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         for (int unsigned k = 0; k < PRE_CHECK; k++) begin
            pre_q[k] <= '0;
         end
      end else if (pre_we_c) begin
         pre_q[cnt_q[TAP_IDX_W-1:0]] <= pre_val_c;
      end
   end

   assign ack         = ack_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wr_en   = mem_wr_en_q;
   assign mem_wr_data = mem_wr_data_q;
   assign tap_sel     = tap_sel_q;
   assign lfsr_seed   = seed_q;
   assign match_err   = match_err_q;
   assign parity_errs = perr_q;

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Directed self-checking bench for lfsr_decrypt_engine with a behavioural
// data memory and an encryption model that builds the ciphertext image.
module tb_lfsr_decrypt_engine;

   logic       clk = 1'b0;
   logic       init_n;
   logic       req;
   logic       ack;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;
   logic [3:0] tap_sel;
   logic [6:0] lfsr_seed;
   logic       match_err;
   logic [6:0] parity_errs;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [256];
   logic [7:0] exp_plain [64];
   int         wr_count = 0;
   string      msg = "Knowledge comes, but wisdom lingers";

   always #5 clk = ~clk;

   lfsr_decrypt_engine dut (
      .clk         (clk),
      .init_n      (init_n),
      .req         (req),
      .ack         (ack),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data),
      .tap_sel     (tap_sel),
      .lfsr_seed   (lfsr_seed),
      .match_err   (match_err),
      .parity_errs (parity_errs)
   );

   assign mem_rd_data = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_wr_en) begin
         mem[mem_addr] <= mem_wr_data;
         wr_count      <= wr_count + 1;
      end
   end

   function automatic logic [6:0] tb_step(input logic [6:0] s, input logic [6:0] tap);
      return {s[5:0], ^(s & tap)};
   endfunction

   // Encrypt: pre_len spaces, the message, space padding; bit7 = parity of [6:0].
   task automatic build_image(input logic [6:0] tap, input logic [6:0] seed, input int pre_len);
      logic [6:0] s;
      logic [7:0] p;
      logic [6:0] x;
      s = seed;
      for (int i = 0; i < 64; i++) begin
         if (i < pre_len) p = 8'h20;
         else if (i - pre_len < msg.len()) p = msg[i - pre_len];
         else p = 8'h20;
         exp_plain[i] = p;
         x = p[6:0] ^ s;
         mem[64 + i] = {^x, x};
         mem[i] = 8'hFF;
         s = tb_step(s, tap);
      end
   endtask

   // Pulse req high in IDLE, drop it, count clocks until ack (bounded).
   task automatic start_and_wait(output int cyc);
      req = 1'b1;
      repeat (3) @(negedge clk);
      req = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end while (!ack && cyc < 3000);
      checks++;
      if (ack !== 1'b1) begin
         errors++;
         $display("FAIL ack_timeout: ack=%b after %0d cycles, required 1", ack, cyc);
      end
   endtask

   task automatic test_reset();
      init_n = 1'b0;
      req    = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ack, mem_wr_en, mem_addr, mem_wr_data, tap_sel, lfsr_seed, match_err, parity_errs}
          !== {1'b0, 1'b0, 8'h00, 8'h00, 4'hF, 7'h00, 1'b0, 7'h00}) begin
         errors++;
         $display("FAIL reset_values: ack=%b we=%b addr=%h wd=%h tap=%h seed=%h merr=%b perr=%0d",
                  ack, mem_wr_en, mem_addr, mem_wr_data, tap_sel, lfsr_seed, match_err, parity_errs);
      end
      init_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int cyc, base;
      build_image(7'h60, 7'h01, 10);
      base = wr_count;
      start_and_wait(cyc);
      checks++;
      if (cyc !== 149) begin errors++; $display("FAIL basic_latency: got %0d required 149", cyc); end
      checks++;
      if (tap_sel !== 4'd0) begin errors++; $display("FAIL basic_tap_sel: got %0d required 0", tap_sel); end
      checks++;
      if (lfsr_seed !== 7'h01) begin errors++; $display("FAIL basic_seed: got %h required 01", lfsr_seed); end
      checks++;
      if (parity_errs !== 7'd0 || match_err !== 1'b0) begin
         errors++; $display("FAIL basic_status: perr=%0d merr=%b required 0 0", parity_errs, match_err);
      end
      checks++;
      if (wr_count - base !== 64) begin errors++; $display("FAIL basic_writes: got %0d required 64", wr_count - base); end
      checks++;
      if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL basic_we_done: got %b required 0", mem_wr_en); end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (mem[i] !== exp_plain[i]) begin
            errors++; $display("FAIL basic_data[%0d]: got %h required %h", i, mem[i], exp_plain[i]);
         end
      end
   endtask

   task automatic test_tap8();
      int cyc;
      build_image(7'h7B, 7'h7F, 26);
      start_and_wait(cyc);
      checks++;
      if (tap_sel !== 4'd8) begin errors++; $display("FAIL tap8_tap_sel: got %0d required 8", tap_sel); end
      checks++;
      if (lfsr_seed !== 7'h7F) begin errors++; $display("FAIL tap8_seed: got %h required 7f", lfsr_seed); end
      checks++;
      if (match_err !== 1'b0) begin errors++; $display("FAIL tap8_match_err: got %b required 0", match_err); end
      // Eight rejected patterns cost at least one search cycle each.
      checks++;
      if (cyc < 157) begin errors++; $display("FAIL tap8_search_len: got %0d cycles required >= 157", cyc); end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (mem[i] !== exp_plain[i]) begin
            errors++; $display("FAIL tap8_data[%0d]: got %h required %h", i, mem[i], exp_plain[i]);
         end
      end
   endtask

   task automatic test_parity();
      int cyc;
      build_image(7'h60, 7'h01, 10);
      mem[70]  = mem[70] ^ 8'h80;
      mem[100] = mem[100] ^ 8'h80;
      start_and_wait(cyc);
      checks++;
      if (parity_errs !== 7'd2) begin errors++; $display("FAIL parity_count: got %0d required 2", parity_errs); end
      checks++;
      if (cyc !== 149) begin errors++; $display("FAIL parity_latency: got %0d required 149", cyc); end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (mem[i] !== exp_plain[i]) begin
            errors++; $display("FAIL parity_data[%0d]: got %h required %h", i, mem[i], exp_plain[i]);
         end
      end
   endtask

   task automatic test_no_match();
      int cyc, base;
      build_image(7'h60, 7'h01, 10);
      for (int i = 64; i < 74; i++) mem[i] = 8'h00;
      base = wr_count;
      start_and_wait(cyc);
      checks++;
      if (match_err !== 1'b1) begin errors++; $display("FAIL nomatch_err: got %b required 1", match_err); end
      checks++;
      if (tap_sel !== 4'hF) begin errors++; $display("FAIL nomatch_tap_sel: got %h required f", tap_sel); end
      checks++;
      if (wr_count - base !== 0) begin errors++; $display("FAIL nomatch_writes: got %0d required 0", wr_count - base); end
      checks++;
      if (lfsr_seed !== 7'h20) begin errors++; $display("FAIL nomatch_seed: got %h required 20", lfsr_seed); end
      // 1 + 10 + 9 single-cycle aborts + 1.
      checks++;
      if (cyc !== 21) begin errors++; $display("FAIL nomatch_latency: got %0d required 21", cyc); end
   endtask

   task automatic test_reset_mid_run();
      int cyc, base, n;
      build_image(7'h60, 7'h01, 10);
      base = wr_count;
      req = 1'b1;
      repeat (3) @(negedge clk);
      req = 1'b0;
      n = 0;
      while (wr_count - base < 30 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (wr_count - base !== 30) begin errors++; $display("FAIL midrst_reach: writes %0d required 30", wr_count - base); end
      init_n = 1'b0;
      #1;
      checks++;
      if ({ack, mem_wr_en, mem_addr, mem_wr_data, tap_sel, lfsr_seed, match_err, parity_errs}
          !== {1'b0, 1'b0, 8'h00, 8'h00, 4'hF, 7'h00, 1'b0, 7'h00}) begin
         errors++;
         $display("FAIL midrst_values: ack=%b we=%b addr=%h wd=%h tap=%h seed=%h merr=%b perr=%0d",
                  ack, mem_wr_en, mem_addr, mem_wr_data, tap_sel, lfsr_seed, match_err, parity_errs);
      end
      @(negedge clk);
      init_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (mem[30] !== 8'hFF || ack !== 1'b0) begin
         errors++; $display("FAIL midrst_after: mem[30]=%h ack=%b required ff 0", mem[30], ack);
      end
      build_image(7'h60, 7'h01, 10);
      start_and_wait(cyc);
      checks++;
      if (cyc !== 149 || tap_sel !== 4'd0) begin
         errors++; $display("FAIL midrst_rerun: cycles %0d tap %0d required 149 0", cyc, tap_sel);
      end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (mem[i] !== exp_plain[i]) begin
            errors++; $display("FAIL midrst_data[%0d]: got %h required %h", i, mem[i], exp_plain[i]);
         end
      end
   endtask

   task automatic test_ack_hold();
      int cyc, base;
      bit dropped;
      base = wr_count;
      dropped = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ack !== 1'b1) dropped = 1'b1;
      end
      checks++;
      if (dropped || wr_count - base !== 0) begin
         errors++; $display("FAIL hold_ack: dropped=%b writes=%0d required 0 0", dropped, wr_count - base);
      end
      req = 1'b1;
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL release_ack: got %b required 0", ack); end
      // Drop req in the same cycle ack releases: this edge must not launch a run.
      req = 1'b0;
      build_image(7'h60, 7'h01, 10);
      base = wr_count;
      repeat (40) @(negedge clk);
      checks++;
      if (wr_count - base !== 0 || ack !== 1'b0 || mem_addr !== 8'h00) begin
         errors++; $display("FAIL ignored_edge: writes=%0d ack=%b addr=%h required 0 0 00",
                            wr_count - base, ack, mem_addr);
      end
      start_and_wait(cyc);
      checks++;
      if (cyc !== 149 || wr_count - base !== 64) begin
         errors++; $display("FAIL restart_run: cycles %0d writes %0d required 149 64", cyc, wr_count - base);
      end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (mem[i] !== exp_plain[i]) begin
            errors++; $display("FAIL restart_data[%0d]: got %h required %h", i, mem[i], exp_plain[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      init_n = 1'b0;
      req    = 1'b0;
      test_reset();
      test_basic();
      test_tap8();
      test_parity();
      test_no_match();
      test_reset_mid_run();
      test_ack_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_decrypt_engine.md
Name: lfsr_decrypt_engine

Overview:
Hardware decryption accelerator for the program-2 flow. It sits beside data memory and consumes the 64 encrypted bytes at addresses 64..127 that the encryption stage produces.
- Recovers the LFSR tap pattern and starting state from the known ASCII-space preamble.
- Writes the 64 decrypted bytes to addresses 0..63.
- Reports completion on the same req/ack handshake used by top_level.

Parameters:
MSG_BASE, 64, data-memory address of encrypted byte 0
OUT_BASE, 0, data-memory address of decrypted byte 0
MSG_LEN, 64, bytes processed per run
PRE_CHECK, 10, preamble bytes used for pattern search (minimum preamble length)
PAD_CHAR, 8'h20, known preamble plaintext

Ports:
clk  in  1  system clock, rising edge
init_n  in  1  asynchronous active-low reset
req  in  1  level start request; high = hold, 1->0 transition launches a run
ack  out  1  run complete; held high until req returns high
mem_addr  out  8  data-memory address (asynchronous read, synchronous write)
mem_rd_data  in  8  read data for mem_addr, same cycle
mem_wr_en  out  1  write strobe
mem_wr_data  out  8  write data
tap_sel  out  4  index 0..8 of the matched pattern; 4'hF if none
lfsr_seed  out  7  recovered starting state
match_err  out  1  no pattern matched the preamble
parity_errs  out  7  count of received bytes whose bit7 != ^bits[6:0]

Behaviour:
- Reset (init_n=0, any state, including mid-run): state IDLE, ack=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, tap_sel=4'hF, lfsr_seed=0, match_err=0, parity_errs=0. An in-flight write is dropped.
- Tap table, constant and index-ordered: 60,48,78,72,6A,69,5C,7E,7B (hex, 7-bit).
- LFSR step: next = {s[5:0], ^(s & tap)}.
- IDLE: req is registered as req_q. When req_q=1 and req=0, go to LOAD and clear the status outputs.
- LOAD, 10 cycles:
  - mem_addr = MSG_BASE+k, k = 0..9.
  - Store k_i = mem_rd_data[6:0] ^ PAD_CHAR[6:0] into preamble regs p[0..9].
  - lfsr_seed = p[0] after LOAD.
- SEARCH, per pattern index t = 0..8:
  - Run state s from p[0].
  - Each cycle compare step(s) against p[j], j = 1..9.
  - Mismatch: abort; next cycle starts t+1 from p[0].
  - All 9 match: tap_sel = t, go to DECRYPT.
  - t = 8 fails: match_err = 1, go to DONE. No memory writes in this case.
  - Lowest matching index wins. Worst case 81 cycles.
- DECRYPT, 2 cycles per byte i = 0..63, LFSR seeded p[0]:
  - Read cycle: mem_addr = MSG_BASE+i. Latch the byte. If the parity check fails, increment parity_errs; it saturates at 127.
  - Write cycle: mem_addr = OUT_BASE+i, mem_wr_en = 1, mem_wr_data = {1'b0, c[6:0] ^ s}. The LFSR then steps.
  - Parity failures do not stop decryption.
  - After i = 63: DONE. Exactly 128 DECRYPT cycles, 64 writes.
- DONE: ack = 1, mem_wr_en = 0. Status outputs hold. When req = 1, go to IDLE (ack = 0 next cycle).
- Simultaneous req 1->0 with the ack release: the edge is ignored. A new run needs req high then low while in IDLE.
- req toggling during LOAD/SEARCH/DECRYPT is ignored.
- Address arithmetic is 8-bit. No wrap occurs at the defaults; MSG_BASE+MSG_LEN <= 256 is required.
- Latency from the req falling edge to ack: 1 + 10 + search cycles + 128 + 1.

Decomposition:
- Package decrypt_pkg:
  - state enum {IDLE, LOAD, SEARCH, DECRYPT, DONE}
  - TAP_TABLE[9] constant
  - PAD_CHAR
  - lfsr_step function
- One sub-module, lfsr7_step: holds the state register with load, step and tap inputs. It is shared by SEARCH and DECRYPT.

Test Plan:
- Tap 0x60, seed 0x01, preamble 10, message "Knowledge comes, but wisdom lingers":
  - Memory[64] = 0x21 and the rest from the encryption model.
  - Required: tap_sel = 0, lfsr_seed = 0x01, memory[0..63] equals the padded plaintext, parity_errs = 0, ack after 1+10+9+128+1 cycles.
- Tap 0x7B (index 8), seed 0x7F, preamble 26: tap_sel = 8; search takes the abort path through indices 0..7 with no spurious early match; decrypt is correct.
- Same as the first case, but flip bit7 of memory[70] and memory[100]: parity_errs = 2; decrypted data is still correct.
- Preamble bytes that fit no pattern (all 0x00 at 64..73): match_err = 1, tap_sel = 4'hF, no mem_wr_en pulses, ack asserted.
- Assert init_n = 0 during DECRYPT at i = 30, then release: all outputs return to reset values, ack = 0. A subsequent req high->low reruns and completes correctly.
- Hold req low after ack: ack stays high and no second run starts. Raise req: ack = 0 on the next cycle. Lowering req again starts a run.
